router_out_arb: RTL and testbench

ROUTER_OUT_ARB -- requirements
Module: router_out_arb

---
 rtl/router_out_arb.sv | 225 ++++++++++++++++++++++
 tb/tb_router_out_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_arb.sv
// rtl/router_out_arb.sv - packet-atomic round-robin egress arbiter for three router output FIFOs
// Optional stall-timeout flush is enabled by defining ROUTER_OUT_ARB_TIMEOUT_EN.
module router_out_arb #(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    input  logic       out_ready,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2,
    output logic       busy,
    output logic [1:0] grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_RD,
        S_HDR_LEN,
        S_PAYLOAD,
        S_FLUSH
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [6:0] remain_q, remain_d;
    logic       valid_q, valid_d;
    logic [7:0] hold_q, hold_d;
    // FIFO read data arrives one cycle after the strobe; rd_q marks that cycle
    logic       rd_q;

    logic [2:0] empty_v;
    logic       sel_empty;
    logic [7:0] data_sel;
    logic [1:0] c0, c1, c2;
    logic       found;
    logic [1:0] pick;
    logic       issue;
    logic       accept;
    logic       timeout_hit;

    assign empty_v = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign accept  = valid_q && out_ready;

    always_comb begin
        case (grant_q)
            2'd0: begin
                sel_empty = fifo_empty_0;
                data_sel  = data_out_0;
            end
            2'd1: begin
                sel_empty = fifo_empty_1;
                data_sel  = data_out_1;
            end
            default: begin
                sel_empty = fifo_empty_2;
                data_sel  = data_out_2;
            end
        endcase
    end

    // Round-robin candidates, starting just past the last served FIFO
    always_comb begin
        case (grant_q)
            2'd0: begin
                c0 = 2'd1;
                c1 = 2'd2;
                c2 = 2'd0;
            end
            2'd1: begin
                c0 = 2'd2;
                c1 = 2'd0;
                c2 = 2'd1;
            end
            default: begin
                c0 = 2'd0;
                c1 = 2'd1;
                c2 = 2'd2;
            end
        endcase
        found = 1'b1;
        pick  = grant_q;
        if (!empty_v[c0]) begin
            pick = c0;
        end else if (!empty_v[c1]) begin
            pick = c1;
        end else if (!empty_v[c2]) begin
            pick = c2;
        end else begin
            found = 1'b0;
        end
    end

`ifdef ROUTER_OUT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic             stalled;

    assign stalled     = (state_q != S_IDLE) && valid_q && !out_ready;
    assign timeout_hit = stalled && (stall_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        stall_d = '0;
        if (stalled && !timeout_hit) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign unused_cfg  = (TIMEOUT > 0);
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            grant_q  <= 2'd2;
            remain_q <= '0;
            valid_q  <= 1'b0;
            hold_q   <= '0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            remain_q <= remain_d;
            valid_q  <= valid_d;
            hold_q   <= hold_d;
            rd_q     <= issue;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        remain_d = remain_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = S_HDR_RD;
                end
            end
            S_HDR_RD: begin
                if (issue) begin
                    state_d = S_HDR_LEN;
                end
            end
            S_HDR_LEN: begin
                // payload bytes plus the trailing parity byte
                remain_d = 7'(out_data[7:2]) + 7'd1;
                state_d  = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (issue) begin
                    remain_d = remain_q - 7'd1;
                    if (remain_q == 7'd1) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (!valid_q || accept) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_d  = S_IDLE;
            remain_d = '0;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (issue) begin
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        if (timeout_hit) begin
            valid_d = 1'b0;
        end
        hold_d = rd_q ? data_sel : hold_q;
    end

    always_comb begin
        issue = 1'b0;
        if ((state_q == S_HDR_RD) || ((state_q == S_PAYLOAD) && (remain_q != 7'd0))) begin
            issue = !sel_empty && (!valid_q || out_ready);
        end
        read_enb_0   = issue && (grant_q == 2'd0);
        read_enb_1   = issue && (grant_q == 2'd1);
        read_enb_2   = issue && (grant_q == 2'd2);
        soft_reset_0 = timeout_hit && (grant_q == 2'd0);
        soft_reset_1 = timeout_hit && (grant_q == 2'd1);
        soft_reset_2 = timeout_hit && (grant_q == 2'd2);
        busy         = (state_q != S_IDLE);
        grant        = grant_q;
        out_valid    = valid_q;
        out_data     = rd_q ? data_sel : hold_q;
    end

endmodule

// File: tb/tb_router_out_arb.sv
// tb/tb_router_out_arb.sv - randomized and directed bench for router_out_arb against a packet-level model
module tb_router_out_arb;

    localparam int TO     = 30;
    localparam int M_ON   = 0;
    localparam int M_RAND = 1;
    localparam int M_BP   = 2;
    localparam int M_TO   = 3;

    logic       clock = 1'b0;
    logic       resetn;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       out_ready;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       out_valid;
    logic [7:0] out_data;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       busy;
    logic [1:0] grant;

    router_out_arb #(.TIMEOUT(TO)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .fifo_empty_0(fifo_empty_0),
        .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .data_out_2  (data_out_2),
        .out_ready   (out_ready),
        .read_enb_0  (read_enb_0),
        .read_enb_1  (read_enb_1),
        .read_enb_2  (read_enb_2),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .soft_reset_0(soft_reset_0),
        .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2),
        .busy        (busy),
        .grant       (grant)
    );

    always #5 clock = ~clock;

    // Registered-read FIFO models: flushed by reset or the matching soft_reset
    logic [7:0] mem [3][256];
    logic [7:0] wr_ptr [3];
    logic [7:0] rd_ptr [3];
    logic [7:0] dout [3];
    logic [2:0] re_v, sr_v;

    assign re_v = {read_enb_2, read_enb_1, read_enb_0};
    assign sr_v = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign fifo_empty_0 = (rd_ptr[0] == wr_ptr[0]);
    assign fifo_empty_1 = (rd_ptr[1] == wr_ptr[1]);
    assign fifo_empty_2 = (rd_ptr[2] == wr_ptr[2]);
    assign data_out_0 = dout[0];
    assign data_out_1 = dout[1];
    assign data_out_2 = dout[2];

    always @(posedge clock) begin
        for (int f = 0; f < 3; f++) begin
            if (!resetn || sr_v[f]) begin
                rd_ptr[f] <= wr_ptr[f];
            end else if (re_v[f]) begin
                dout[f]   <= mem[f][rd_ptr[f]];
                rd_ptr[f] <= rd_ptr[f] + 8'd1;
            end
        end
    end

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] m_bytes [3][$];
    int         m_len [3][$];
    logic [7:0] exp_b [$];
    int         exp_g [$];
    int         last_g;

    int  rdy_mode, bp_left, bp_n, acc_count, busy_n, first_busy, cyc;
    bit  bp_done, to_hold, to_test, rst_req, prev_stall, prev_busy;
    logic [7:0] prev_data;
    logic [2:0] ren, srv;
    int  rd_log [3][$];
    int  obs_order [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input int f, input logic [7:0] b);
        mem[f][wr_ptr[f]] = b;
        wr_ptr[f] = wr_ptr[f] + 8'd1;
        m_bytes[f].push_back(b);
    endtask

    task automatic push_pkt(input int f, input logic [7:0] hdr, input bit rnd);
        int         len;
        logic [7:0] b, par;
        len = int'(hdr[7:2]);
        par = hdr;
        put(f, hdr);
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : 8'(8'h11 * (i + 1));
            par ^= b;
            put(f, b);
        end
        put(f, par);
        m_len[f].push_back(len + 2);
    endtask

    // Whole packets in round-robin order from the last served FIFO
    task automatic plan();
        int g, n;
        while (m_len[0].size() + m_len[1].size() + m_len[2].size() > 0) begin
            g = -1;
            for (int k = 1; k <= 3; k++) begin
                if (g < 0 && m_len[(last_g + k) % 3].size() > 0) g = (last_g + k) % 3;
            end
            n = m_len[g].pop_front();
            repeat (n) begin
                exp_b.push_back(m_bytes[g].pop_front());
                exp_g.push_back(g);
            end
            last_g = g;
        end
    endtask

    task automatic reset_model();
        for (int f = 0; f < 3; f++) begin
            m_bytes[f].delete();
            m_len[f].delete();
        end
        exp_b.delete();
        exp_g.delete();
        last_g = 2;
    endtask

    task automatic start_test();
        for (int f = 0; f < 3; f++) rd_log[f].delete();
        obs_order.delete();
        busy_n = 0;
        acc_count = 0;
        first_busy = -1;
        bp_left = 0;
        bp_n = 0;
        bp_done = 0;
        to_hold = 0;
    endtask

    task automatic tick();
        @(negedge clock);
        resetn = !rst_req;
        case (rdy_mode)
            M_ON:   out_ready = 1'b1;
            M_RAND: out_ready = ($urandom_range(0, 9) < 7);
            M_BP: begin
                if (bp_left > 0) begin
                    out_ready = 1'b0;
                    bp_left--;
                end else if (!bp_done && out_valid && out_data == 8'h22) begin
                    bp_done = 1;
                    bp_left = 4;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: begin
                if (acc_count >= 2 && out_valid) to_hold = 1'b1;
                out_ready = !to_hold;
            end
        endcase
        #1;
        cyc++;
        ren = re_v;
        srv = sr_v;
        check_eq("rd_onehot", $countones(ren) <= 1, 1);
        if (!to_test) check_eq("sr_quiet", srv, 0);
        for (int f = 0; f < 3; f++) if (ren[f]) rd_log[f].push_back(cyc);
        if (busy) busy_n++;
        if (prev_stall) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, prev_data);
        end
        if (rdy_mode == M_BP && !out_ready) begin
            check_eq("bp_data", out_data, 8'h22);
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_no_read", ren, 0);
            bp_n++;
        end
        if (resetn && out_valid && out_ready) begin
            acc_count++;
            check_eq("byte_avail", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) begin
                check_eq("out_data", out_data, exp_b.pop_front());
                check_eq("grant", grant, exp_g.pop_front());
            end
        end
        if (busy && !prev_busy) begin
            obs_order.push_back(int'(grant));
            if (first_busy < 0) first_busy = cyc;
        end
        prev_stall = resetn && out_valid && !out_ready && (srv == 3'b000);
        prev_data  = out_data;
        prev_busy  = busy;
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while ((exp_b.size() > 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check_eq("drained", exp_b.size(), 0);
        check_eq("idle_after", busy, 0);
    endtask

    task automatic check_reset_state();
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_grant", grant, 2);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd", ren, 0);
        check_eq("rst_sr", srv, 0);
    endtask

    task automatic do_reset();
        rst_req = 1;
        tick();
        tick();
        rst_req = 0;
        reset_model();
        tick();
        check_reset_state();
    endtask

`ifdef ROUTER_OUT_ARB_TIMEOUT_EN
    task automatic run_timeout_test();
        int stall_n = 0;
        int early = 0;
        bit done = 0;
        start_test();
        to_test = 1;
        push_pkt(1, 8'h14, 1);
        plan();
        rdy_mode = M_TO;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (busy && out_valid && !out_ready) begin
                stall_n++;
                if (stall_n < TO) begin
                    early += int'(soft_reset_1);
                end else begin
                    check_eq("to_pulse", soft_reset_1, 1);
                    check_eq("to_other_sr", {soft_reset_2, soft_reset_0}, 0);
                    tick();
                    check_eq("to_valid", out_valid, 0);
                    check_eq("to_busy", busy, 0);
                    check_eq("to_pulse_end", soft_reset_1, 0);
                    done = 1;
                end
            end
        end
        check_eq("to_reached", done, 1);
        check_eq("to_no_early", early, 0);
        exp_b.delete();
        exp_g.delete();
        repeat (3) tick();
        check_eq("to_stay_idle", busy, 0);
        to_test = 0;
    endtask
`endif

    initial begin
        resetn = 1'b0;
        out_ready = 1'b0;
        rdy_mode = M_ON;
        rst_req = 1;
        to_test = 0;
        prev_stall = 0;
        prev_busy = 0;
        prev_data = '0;
        cyc = 0;
        for (int f = 0; f < 3; f++) wr_ptr[f] = '0;
        start_test();
        do_reset();

        // single packet, ready always high
        start_test();
        push_pkt(0, 8'h0C, 0);
        plan();
        run_drain(100);
        check_eq("sp_reads", rd_log[0].size(), 5);
        if (rd_log[0].size() == 5) begin
            check_eq("sp_hdr_gap", rd_log[0][1] - rd_log[0][0], 2);
            check_eq("sp_burst", rd_log[0][4] - rd_log[0][1], 3);
            check_eq("sp_busy_start", first_busy, rd_log[0][0]);
        end
        check_eq("sp_busy_cycles", busy_n, 7);
        check_eq("sp_bytes", acc_count, 5);

        // fairness across three FIFOs with two packets each
        do_reset();
        start_test();
        for (int i = 0; i < 2; i++) for (int f = 0; f < 3; f++) push_pkt(f, 8'h04, 1);
        plan();
        run_drain(200);
        check_eq("rr_packets", obs_order.size(), 6);
        for (int i = 0; i < 6 && i < obs_order.size(); i++) check_eq("rr_order", obs_order[i], i % 3);

        // backpressure at the second payload byte
        start_test();
        rdy_mode = M_BP;
        push_pkt(0, 8'h0C, 0);
        plan();
        run_drain(100);
        check_eq("bp_stall_cycles", bp_n, 5);
        check_eq("bp_bytes", acc_count, 5);

        // zero-length packet on FIFO2
        start_test();
        rdy_mode = M_ON;
        push_pkt(2, 8'h01, 0);
        plan();
        run_drain(100);
        check_eq("zl_reads", rd_log[2].size(), 2);
        check_eq("zl_bytes", acc_count, 2);
        check_eq("zl_busy_cycles", busy_n, 4);

        // reset in the middle of a payload
        start_test();
        push_pkt(0, 8'h10, 1);
        plan();
        for (int i = 0; i < 50 && rd_log[0].size() < 3; i++) tick();
        check_eq("mid_in_payload", rd_log[0].size(), 3);
        rst_req = 1;
        tick();
        rst_req = 0;
        reset_model();
        tick();
        check_reset_state();

        // randomized traffic with random backpressure
        rdy_mode = M_RAND;
        for (int r = 0; r < 8; r++) begin
            start_test();
            if (r == 0) push_pkt(1, 8'hFD, 1);
            for (int f = 0; f < 3; f++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = $urandom_range(0, 6);
                    push_pkt(f, {6'(len), 2'($urandom)}, 1);
                end
            end
            plan();
            run_drain(3000);
        end

`ifdef ROUTER_OUT_ARB_TIMEOUT_EN
        run_timeout_test();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
